// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared instruction-format constants for the 16-bit core
//
// Opcode values, field positions/widths, the format enum and the helper that
// maps an opcode onto its encoding format.
package instr_pkg;

  localparam int INSTR_W   = 16;
  localparam int REG_W     = 3;
  localparam int OP_W      = 3;
  localparam int FUNCT_W   = 4;
  localparam int IMM_W     = 13;  // raw immediate input: J target width
  localparam int IMM_I_W   = 7;   // signed immediate kept in I-type words

  localparam int OP_LSB    = 13;
  localparam int RS_LSB    = 10;
  localparam int RT_LSB    = 7;
  localparam int RD_LSB    = 4;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SLTI = 3'b001;
  localparam logic [OP_W-1:0] OP_J    = 3'b010;
  localparam logic [OP_W-1:0] OP_JAL  = 3'b011;
  localparam logic [OP_W-1:0] OP_LW   = 3'b100;
  localparam logic [OP_W-1:0] OP_SW   = 3'b101;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b110;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b111;

  // jal links into this register
  localparam logic [REG_W-1:0] RA_REG = 3'd7;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_e;

  function automatic fmt_e op_format(input logic [OP_W-1:0] op);
    fmt_e f;
    case (op)
      OP_ADD:       f = FMT_R;
      OP_J, OP_JAL: f = FMT_J;
      default:      f = FMT_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// rtl/instr_encode_loader_if.sv - decoded-field bundle handshake between host and loader
//
// Signals:
//   in_valid / in_ready  handshake
//   in_opcode, in_rs, in_rt, in_rd, in_funct, in_imm  decoded instruction fields
// Modports: master (host drives fields), slave (loader accepts them).
interface instr_encode_loader_if;
  import instr_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_opcode;
  logic [REG_W-1:0]    in_rs;
  logic [REG_W-1:0]    in_rt;
  logic [REG_W-1:0]    in_rd;
  logic [FUNCT_W-1:0]  in_funct;
  logic [IMM_W-1:0]    in_imm;

  modport master (
    output in_valid, in_opcode, in_rs, in_rt, in_rd, in_funct, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_funct, in_imm,
    output in_ready
  );

endinterface

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational packer of decoded fields into a 16-bit word
//
// Ports:
//   opcode, rs, rt, rd, funct, imm  in   decoded fields
//   word                            out  packed instruction word
//   imm_ok                          out  immediate fits its field
// Optional: ENCODER_IMM_CHECK_EN enables the I-type signed 7-bit range check;
// without it imm_ok is constant 1 and the immediate is truncated.
module instr_field_packer
  import instr_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [IMM_W-1:0]   imm,
  output logic [INSTR_W-1:0] word,
  output logic               imm_ok
);

  fmt_e fmt;

  always_comb begin
    fmt  = op_format(opcode);
    word = '0;
    word[OP_LSB +: OP_W] = opcode;
    unique case (fmt)
      FMT_R: begin
        word[RS_LSB +: REG_W]      = rs;
        word[RT_LSB +: REG_W]      = rt;
        word[RD_LSB +: REG_W]      = rd;
        word[FUNCT_LSB +: FUNCT_W] = funct;
      end
      FMT_I: begin
        word[RS_LSB +: REG_W]      = rs;
        word[RT_LSB +: REG_W]      = rt;
        word[IMM_LSB +: IMM_I_W]   = imm[IMM_I_W-1:0];
      end
      FMT_J: begin
        word[IMM_LSB +: IMM_W]     = imm;
      end
      default: ;
    endcase
  end

`ifdef ENCODER_IMM_CHECK_EN
  // A 13-bit value fits in signed 7 bits when bits [12:6] are all copies of
  // the sign bit.
  always_comb begin
    imm_ok = (fmt != FMT_I)
          || (imm[IMM_W-1:IMM_I_W-1] == '0)
          || (imm[IMM_W-1:IMM_I_W-1] == '1);
  end
`else
  assign imm_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes field bundles and loads them into instruction memory
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr, load_len, abort   session control
//   bus (slave)              field bundle handshake
//   imem_we, imem_addr, imem_wdata      instruction memory write port
//   cpu_stall, busy, done, err, words_written  status
// Optional: ENCODER_IMM_CHECK_EN (see instr_field_packer) rejects out-of-range
// I-type immediates: the bundle is consumed, err is set, nothing is written.
module instr_encode_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     load_len,
  input  logic                 abort,
  instr_encode_loader_if.slave bus,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0]   imem_wdata,
  output logic                 cpu_stall,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_W-1:0]     words_written
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e               state;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     count_q;
  logic                 err_q;
  logic [INSTR_W-1:0]   word_q;

  logic [INSTR_W-1:0]   packed_word;
  logic                 imm_ok;
  logic                 handshake;
  logic [LEN_W-1:0]     count_inc;
  logic [LEN_W-1:0]     count_next;

  instr_field_packer u_packer (
    .opcode (bus.in_opcode),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .funct  (bus.in_funct),
    .imm    (bus.in_imm),
    .word   (packed_word),
    .imm_ok (imm_ok)
  );

  assign handshake = bus.in_valid && bus.in_ready;
  assign count_inc = count_q + LEN_W'(1);
  // count never runs past the session length
  assign count_next = (count_q == len_q) ? count_q : count_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else if (abort) begin
      // The write presented this cycle still lands, so account for it.
      state <= S_IDLE;
      if (state == S_WRITE) begin
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_next;
      end
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_q  <= base_addr;
            len_q   <= load_len;
            count_q <= '0;
            err_q   <= 1'b0;
            state   <= (load_len == '0) ? S_DONE : S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (handshake) begin
            if (imm_ok) begin
              word_q <= packed_word;
              state  <= S_WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_next;
          state   <= (count_inc >= len_q) ? S_DONE : S_ACCEPT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_ACCEPT);
  // Gate with rst so a write in flight never reaches memory during reset.
  assign imem_we       = (state == S_WRITE) && !rst;
  assign imem_addr     = addr_q;
  assign imem_wdata    = word_q;
  assign cpu_stall     = (state == S_ACCEPT) || (state == S_WRITE);
  assign busy          = (state == S_ACCEPT) || (state == S_WRITE);
  assign done          = (state == S_DONE);
  assign err           = err_q;
  assign words_written = count_q;

endmodule
